// File: rtl/crossy_leds_pkg.sv
// rtl/crossy_leds_pkg.sv - shared FSM states and constants for the LED PIO scheduler
package crossy_leds_pkg;

    localparam int         NUM_LEDS_DEFAULT = 14;
    localparam logic [1:0] PIO_DATA_ADDR    = 2'd0;
    // Wide enough for BLINK_DIV up to 2^26 (counter tops out at BLINK_DIV-1).
    localparam int         BLINK_CNT_W      = 26;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

endpackage

// File: rtl/crossy_blink_timer.sv
// rtl/crossy_blink_timer.sv - blink phase generator; pulses toggle on every phase change or disable
module crossy_blink_timer
    import crossy_leds_pkg::*;
#(
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic phase,
    output logic toggle
);

    localparam logic [BLINK_CNT_W-1:0] LAST = BLINK_CNT_W'(BLINK_DIV - 1);

    logic [BLINK_CNT_W-1:0] r_count;
    logic                   r_phase;
    logic                   r_en_d;
    logic                   w_wrap;
    logic                   w_fall;

    assign w_wrap = enable && (r_count == LAST);
    // Disabling forces the phase back ON; the toggle lets the scheduler restore the PIO.
    assign w_fall = r_en_d && !enable;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            r_phase <= 1'b1;
            r_en_d  <= 1'b0;
        end else begin
            r_en_d <= enable;
            if (w_fall) begin
                r_count <= '0;
                r_phase <= 1'b1;
            end else if (w_wrap) begin
                r_count <= '0;
                r_phase <= ~r_phase;
            end else if (enable) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign phase  = r_phase;
    assign toggle = w_wrap || w_fall;

endmodule

// File: rtl/crossy_leds_scheduler.sv
// rtl/crossy_leds_scheduler.sv - fixed-priority arbiter writing LED words to an Avalon-MM PIO
module crossy_leds_scheduler
    import crossy_leds_pkg::*;
#(
    parameter int NUM_LEDS  = NUM_LEDS_DEFAULT,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                hi_valid,
    input  logic [NUM_LEDS-1:0] hi_data,
    output logic                hi_ready,
    input  logic                lo_valid,
    input  logic [NUM_LEDS-1:0] lo_data,
    output logic                lo_ready,
    input  logic                blink_en,
    input  logic [NUM_LEDS-1:0] blink_mask,
    output logic [1:0]          pio_address,
    output logic                pio_chipselect,
    output logic                pio_write_n,
    output logic [31:0]         pio_writedata,
    output logic [NUM_LEDS-1:0] led_shadow,
    output logic                busy
);

    state_t              r_state;
    state_t              w_next;
    logic [NUM_LEDS-1:0] r_shadow;
    logic [NUM_LEDS-1:0] r_last;
    logic                r_pending;
    logic                w_phase;
    logic                w_toggle;
    logic                w_hi_grant;
    logic                w_lo_grant;
    logic                w_blink_grant;
    logic [NUM_LEDS-1:0] w_grant_data;
    logic [NUM_LEDS-1:0] w_wr_word;

    crossy_blink_timer #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (blink_en),
        .phase   (w_phase),
        .toggle  (w_toggle)
    );

    function automatic logic [NUM_LEDS-1:0] f_overlay(
        input logic [NUM_LEDS-1:0] word,
        input logic                phase_on,
        input logic                en,
        input logic [NUM_LEDS-1:0] mask
    );
        return (phase_on || !en) ? word : (word & ~mask);
    endfunction

    assign w_wr_word = f_overlay(r_shadow, w_phase, blink_en, blink_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_hi_grant     = 1'b0;
        w_lo_grant     = 1'b0;
        w_blink_grant  = 1'b0;
        w_grant_data   = r_shadow;
        pio_chipselect = 1'b0;
        pio_write_n    = 1'b1;
        pio_address    = PIO_DATA_ADDR;
        pio_writedata  = '0;
        busy           = 1'b0;
        case (r_state)
            IDLE: begin
                if (hi_valid) begin
                    w_hi_grant   = 1'b1;
                    w_grant_data = hi_data;
                end else if (lo_valid) begin
                    w_lo_grant   = 1'b1;
                    w_grant_data = lo_data;
                end else if (r_pending) begin
                    w_blink_grant = 1'b1;
                end
                // A word identical to what the PIO already shows is accepted but not rewritten.
                if ((w_hi_grant || w_lo_grant || w_blink_grant) &&
                    (f_overlay(w_grant_data, w_phase, blink_en, blink_mask) != r_last)) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                pio_chipselect                = 1'b1;
                pio_write_n                   = 1'b0;
                pio_writedata[NUM_LEDS-1:0]   = w_wr_word;
                busy                          = 1'b1;
                w_next                        = IDLE;
            end
            default: w_next = IDLE;
        endcase
        hi_ready = w_hi_grant && reset_n;
        lo_ready = w_lo_grant && reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow  <= '0;
            r_last    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_hi_grant || w_lo_grant) begin
                r_shadow <= w_grant_data;
            end
            if (r_state == WRITE) begin
                r_last <= w_wr_word;
            end
            // A toggle landing on the same edge as a grant must not be lost.
            if (w_toggle) begin
                r_pending <= 1'b1;
            end else if (w_blink_grant) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign led_shadow = r_shadow;

endmodule

// File: tb/tb_crossy_leds_scheduler.sv
// tb/tb_crossy_leds_scheduler.sv - directed self-checking bench for crossy_leds_scheduler
module tb_crossy_leds_scheduler;

    localparam int N = 14;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         hi_valid;
    logic [N-1:0] hi_data;
    logic         hi_ready;
    logic         lo_valid;
    logic [N-1:0] lo_data;
    logic         lo_ready;
    logic         blink_en;
    logic [N-1:0] blink_mask;
    logic [1:0]   pio_address;
    logic         pio_chipselect;
    logic         pio_write_n;
    logic [31:0]  pio_writedata;
    logic [N-1:0] led_shadow;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    crossy_leds_scheduler #(
        .NUM_LEDS  (N),
        .BLINK_DIV (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .hi_valid       (hi_valid),
        .hi_data        (hi_data),
        .hi_ready       (hi_ready),
        .lo_valid       (lo_valid),
        .lo_data        (lo_data),
        .lo_ready       (lo_ready),
        .blink_en       (blink_en),
        .blink_mask     (blink_mask),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .led_shadow     (led_shadow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " cs"},   {31'd0, pio_chipselect}, 32'd0);
        chk({tag, " wn"},   {31'd0, pio_write_n},    32'd1);
        chk({tag, " busy"}, {31'd0, busy},           32'd0);
    endtask

    task automatic chk_write(input string tag, input logic [31:0] data);
        chk({tag, " cs"},   {31'd0, pio_chipselect}, 32'd1);
        chk({tag, " wn"},   {31'd0, pio_write_n},    32'd0);
        chk({tag, " addr"}, {30'd0, pio_address},    32'd0);
        chk({tag, " busy"}, {31'd0, busy},           32'd1);
        chk({tag, " data"}, pio_writedata,           data);
    endtask

    initial begin
        reset_n    = 1'b0;
        hi_valid   = 1'b0;
        hi_data    = '0;
        lo_valid   = 1'b0;
        lo_data    = '0;
        blink_en   = 1'b0;
        blink_mask = '0;
        #3;
        chk_idle("rst");
        chk("rst addr",   {30'd0, pio_address}, 32'd0);
        chk("rst shadow", {18'd0, led_shadow},  32'd0);
        chk("rst hi_rdy", {31'd0, hi_ready},    32'd0);
        chk("rst lo_rdy", {31'd0, lo_ready},    32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("post-rst");
        end

        // Single high-priority write
        hi_valid = 1'b1;
        hi_data  = 14'h0155;
        #1;
        chk("hi0 ready", {31'd0, hi_ready}, 32'd1);
        chk_idle("hi0 grant");
        tick();
        hi_valid = 1'b0;
        #1;
        chk("hi0 ready drop", {31'd0, hi_ready}, 32'd0);
        chk_write("hi0 wr", 32'h0000_0155);
        chk("hi0 shadow", {18'd0, led_shadow}, 32'h0155);
        tick();
        chk_idle("hi0 done");

        // Simultaneous hi and lo
        hi_valid = 1'b1;
        hi_data  = 14'h0001;
        lo_valid = 1'b1;
        lo_data  = 14'h0002;
        #1;
        chk("both hi_rdy", {31'd0, hi_ready}, 32'd1);
        chk("both lo_rdy", {31'd0, lo_ready}, 32'd0);
        tick();
        hi_valid = 1'b0;
        #1;
        chk_write("both wr1", 32'h1);
        chk("both lo_rdy busy", {31'd0, lo_ready}, 32'd0);
        tick();
        chk("both lo_rdy idle", {31'd0, lo_ready}, 32'd1);
        chk_idle("both gap");
        tick();
        lo_valid = 1'b0;
        #1;
        chk_write("both wr2", 32'h2);
        chk("both shadow", {18'd0, led_shadow}, 32'h0002);
        tick();

        // Write 0155 then repeat it: second request is suppressed
        hi_valid = 1'b1;
        hi_data  = 14'h0155;
        tick();
        hi_valid = 1'b0;
        #1;
        chk_write("rep first", 32'h155);
        tick();
        hi_valid = 1'b1;
        #1;
        chk("rep ready", {31'd0, hi_ready}, 32'd1);
        tick();
        hi_valid = 1'b0;
        #1;
        chk_idle("rep suppressed");
        chk("rep shadow", {18'd0, led_shadow}, 32'h0155);

        // Load all-ones, then blink the low nibble with BLINK_DIV=4
        hi_valid = 1'b1;
        hi_data  = 14'h3FFF;
        tick();
        hi_valid = 1'b0;
        #1;
        chk_write("ones wr", 32'h3FFF);
        tick();
        blink_mask = 14'h000F;
        blink_en   = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (k >= 5 && (k % 4) == 1) begin
                chk_write($sformatf("blink k%0d", k), (((k - 5) / 4) % 2 == 0) ? 32'h3FF0 : 32'h3FFF);
            end else begin
                chk_idle($sformatf("blink k%0d", k));
            end
        end

        // Drop blink_en while the phase is OFF: PIO restored to the shadow
        tick();
        blink_en = 1'b0;
        tick();
        chk("restore count", {6'd0, dut.u_blink.r_count}, 32'd0);
        chk_idle("restore grant");
        tick();
        chk_write("restore wr", 32'h3FFF);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle("restore quiet");
        end

        // Reset asserted during a WRITE cycle
        hi_valid = 1'b1;
        hi_data  = 14'h0AAA;
        tick();
        #1;
        chk_write("rstw wr", 32'h0AAA);
        reset_n = 1'b0;
        #1;
        chk_idle("rstw abort");
        chk("rstw shadow", {18'd0, led_shadow}, 32'd0);
        chk("rstw hi_rdy", {31'd0, hi_ready},   32'd0);
        tick();
        hi_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_idle("rstw quiet");
        end
        chk("rstw shadow end", {18'd0, led_shadow}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
